conv2_seq_ctrl: RTL

- Sequencer for the 2nd convolution layer. It gates the stream of pooled 12x12 layer-1 pixels into the three per-channel 5x5 window buffers.
- It tracks raster position and tells the three calc units when a full 5x5 window is present.
- It re-times that window strobe through the calc pipeline latency to produce the conv2 output strobe and output coordinates.
- It frames each 12x12 map with a start/busy/done handshake and throttles input on downstream stall.

---
 rtl/conv2_seq_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/conv2_seq_ctrl.sv
// rtl/conv2_seq_ctrl.sv - conv2 sequencer: gates pooled 12x12 pixels into the 5x5
// window buffers, strobes complete windows and re-times them into output coordinates.
module conv2_seq_ctrl #(
  parameter int WIDTH    = 12,
  parameter int HEIGHT   = 12,
  parameter int K        = 5,
  parameter int CALC_LAT = 2,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic          stall,
  output logic          in_ready,
  output logic          shift_en,
  output logic          win_valid,
  output logic          out_valid,
  output logic [CW-1:0] out_col,
  output logic [CW-1:0] out_row,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] WIN_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] OCOL_LAST = CW'(WIDTH - K);
  localparam logic [CW-1:0] OROW_LAST = CW'(HEIGHT - K);

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [CW-1:0]        row_q, row_d;
  logic [CW-1:0]        ocol_q, ocol_d;
  logic [CW-1:0]        orow_q, orow_d;
  logic                 win_q, win_d;
  logic [CALC_LAT-1:0]  dly_q;
  logic [CALC_LAT-1:0]  dly_shift;
  logic                 col_wrap;
  logic                 last_pix;
  logic                 win_hit;
  logic                 pending;

  // Next contents of the delay line; anything non-zero here means a result is
  // still ahead of the final stage.
  generate
    if (CALC_LAT == 1) begin : g_lat1
      assign dly_shift = win_q;
    end else begin : g_latn
      assign dly_shift = {dly_q[CALC_LAT-2:0], win_q};
    end
  endgenerate

  always_comb begin
    col_wrap  = (col_q == COL_LAST);
    last_pix  = col_wrap && (row_q == ROW_LAST);
    win_hit   = (row_q >= WIN_FIRST) && (col_q >= WIN_FIRST);
    pending   = |dly_shift;
    in_ready  = (state_q == S_RUN) && !stall;
    shift_en  = in_valid && in_ready;
    win_d     = shift_en && win_hit;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (shift_en) begin
          if (last_pix) begin
            state_d = S_DRAIN;
            col_d   = '0;
            row_d   = '0;
          end else if (col_wrap) begin
            col_d = '0;
            row_d = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output coordinates count emitted results, independent of the input raster.
  always_comb begin
    ocol_d = ocol_q;
    orow_d = orow_q;
    if ((state_q == S_IDLE) && start) begin
      ocol_d = '0;
      orow_d = '0;
    end else if (out_valid) begin
      if (ocol_q == OCOL_LAST) begin
        ocol_d = '0;
        orow_d = (orow_q == OROW_LAST) ? '0 : orow_q + CW'(1);
      end else begin
        ocol_d = ocol_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      win_q   <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      win_q   <= win_d;
      dly_q   <= dly_shift;
    end
  end

  always_comb begin
    win_valid  = win_q;
    out_valid  = dly_q[CALC_LAT-1];
    out_col    = ocol_q;
    out_row    = orow_q;
    out_last   = out_valid && (ocol_q == OCOL_LAST) && (orow_q == OROW_LAST);
    busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    frame_done = (state_q == S_DONE);
  end

endmodule
